// File: rtl/booth4_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle is reduced into a
// shifted accumulator, and the unsigned 2*WIDTH-bit product is returned over valid/ready.
module booth4_seq_mul #(
    parameter int unsigned WIDTH = 24
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               busy_o
);
    localparam int unsigned ITER = (WIDTH + 2) / 2;
    localparam int unsigned QW   = 2 * ITER + 1;
    localparam int unsigned AW   = 2 * WIDTH + 4;
    localparam int unsigned PW   = WIDTH + 3;
    localparam int unsigned CW   = $clog2(ITER) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH+1:0]   a_q, a_d;
    logic [QW-1:0]      q_q, q_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [PW-1:0] a_x1, a_x2, pp;
    logic [AW-1:0] pp_sx, pp_sh, acc_sum;
    logic          last_digit;

    // Booth digit decode on the current window {q[2], q[1], q[0]}; q[0] carries b[-1]
    assign a_x1 = {a_q[WIDTH+1], a_q};
    assign a_x2 = {a_q, 1'b0};

    always_comb begin
        pp = '0;
        case (q_q[2:0])
            3'b001, 3'b010: pp = a_x1;
            3'b011:         pp = a_x2;
            3'b100:         pp = ~a_x2 + PW'(1);
            3'b101, 3'b110: pp = ~a_x1 + PW'(1);
            default:        pp = '0;
        endcase
    end

    assign pp_sx      = {{(AW-PW){pp[PW-1]}}, pp};
    assign pp_sh      = pp_sx << {cnt_q, 1'b0};
    assign acc_sum    = acc_q + pp_sh;
    assign last_digit = (cnt_q == CNT_LAST);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (valid_i) state_d = S_RUN;
                S_RUN:   if (last_digit) state_d = S_DONE;
                S_DONE:  if (ready_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (state_q == S_IDLE && valid_i) begin
            a_d   = {2'b00, a_i};
            q_d   = {{(QW-WIDTH-1){1'b0}}, b_i, 1'b0};
            acc_d = '0;
            cnt_d = '0;
        end else if (state_q == S_RUN) begin
            acc_d = acc_sum;
            q_d   = q_q >> 2;
            cnt_d = last_digit ? '0 : cnt_q + CW'(1);
            // product register only moves on entry to DONE, so it holds through IDLE
            if (last_digit) prod_d = acc_sum[2*WIDTH-1:0];
        end
    end

    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            S_IDLE:  ready_o = 1'b1;
            S_RUN:   busy_o  = 1'b1;
            S_DONE: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
            end
            default: ready_o = 1'b0;
        endcase
    end

    assign prod_o = prod_q;

endmodule
